// File: rtl/zpsram_burst_wr_if.sv
// Request / FIFO / pad bundle for the PSRAM linear-burst writer.
//   iEn, iAddr, iLen : level request plus burst descriptor
//   iData, oData_Req : FWFT write-data head and its pop strobe
//   oPSRAM_*, oADQ*, oDQS_DM* : pad-side values and output enables
//   oBusy, oDone, oErr : status back to the requester
// master = requester/FIFO/pad mux side, slave = the burst writer.
interface zpsram_burst_wr_if;
  logic        iEn;
  logic [31:0] iAddr;
  logic [7:0]  iLen;
  logic [7:0]  iData;
  logic        oData_Req;
  logic        oPSRAM_CLK;
  logic        oPSRAM_CE;
  logic [7:0]  oADQ;
  logic        oADQ_OE;
  logic        oDQS_DM;
  logic        oDQS_DM_OE;
  logic        oBusy;
  logic        oDone;
  logic        oErr;

  modport master (
    output iEn, iAddr, iLen, iData,
    input  oData_Req, oPSRAM_CLK, oPSRAM_CE, oADQ, oADQ_OE,
           oDQS_DM, oDQS_DM_OE, oBusy, oDone, oErr
  );

  modport slave (
    input  iEn, iAddr, iLen, iData,
    output oData_Req, oPSRAM_CLK, oPSRAM_CE, oADQ, oADQ_OE,
           oDQS_DM, oDQS_DM_OE, oBusy, oDone, oErr
  );
endinterface

// File: rtl/zpsram_burst_wr.sv
// Bit-banged HyperRAM/APS PSRAM linear-burst write initiator (cmd 0xA0).
// Every PSRAM edge takes two iClk cycles: SETUP loads ADQ, TOGGLE flips CLK,
// so ADQ is stable one iClk before and after each CLK transition.
// Ports:
//   iClk    : 48 MHz fabric clock
//   iRst_N  : asynchronous active-low reset (CE released at once)
//   bus     : slave side of zpsram_burst_wr_if (request, FWFT data, pads,
//             status)
module zpsram_burst_wr #(
  parameter int unsigned LATENCY  = 5,
  parameter int unsigned CE_SETUP = 3,
  parameter int unsigned CE_HOLD  = 6,
  parameter int unsigned MAX_LEN  = 24
) (
  input  logic             iClk,
  input  logic             iRst_N,
  zpsram_burst_wr_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_CE_LOW, S_SETUP, S_TOGGLE, S_HOLD, S_DONE
  } state_t;

  localparam logic [7:0] CMD_WR    = 8'hA0;
  // 2 command edges + 4 address edges + LATENCY full dummy clocks
  localparam logic [7:0] HDR_EDGES = 8'(6 + 2 * LATENCY);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [7:0] SETUP_LD  = 8'(CE_SETUP - 1);
  localparam logic [7:0] HOLD_LD   = 8'(CE_HOLD - 1);

  state_t      state, nextState;
  logic [31:0] addrReg;
  logic [7:0]  byteCnt, dlyCnt, edgeIdx;
  logic        armed, rejReg;
  logic        clkReg, ceReg, adqOeReg, dqsOeReg, busyReg, doneReg, errReg;
  logic [7:0]  adqReg;

  logic        accept, lenOk, inData, lastEdge, dataReq;
  logic [7:0]  adqNext;

  // Only even, non-zero lengths keep the burst ending on a falling edge.
  assign lenOk    = (bus.iLen != 8'd0) && !bus.iLen[0] && (bus.iLen <= MAX_LEN_B);
  assign accept   = (state == S_IDLE) && bus.iEn && armed;
  assign inData   = (edgeIdx >= HDR_EDGES);
  // byteCnt was already decremented in the SETUP half of this edge.
  assign lastEdge = inData && (byteCnt == 8'd0);

  // State register
  always_ff @(posedge iClk or negedge iRst_N) begin
    if (!iRst_N) state <= S_IDLE;
    else         state <= nextState;
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      S_IDLE:   if (accept) nextState = lenOk ? S_CE_LOW : S_DONE;
      S_CE_LOW: if (dlyCnt == 8'd0) nextState = S_SETUP;
      S_SETUP:  nextState = S_TOGGLE;
      S_TOGGLE: nextState = lastEdge ? S_HOLD : S_SETUP;
      S_HOLD:   if (dlyCnt == 8'd0) nextState = S_DONE;
      S_DONE:   nextState = S_IDLE;
      default:  nextState = S_IDLE;
    endcase
  end

  // Output logic: FIFO pop strobe and the ADQ value for the coming edge.
  always_comb begin
    dataReq = 1'b0;
    adqNext = 8'h00;
    if (inData) begin
      adqNext = bus.iData;
      dataReq = (state == S_SETUP);
    end else begin
      case (edgeIdx)
        8'd0, 8'd1: adqNext = CMD_WR;
        8'd2:       adqNext = addrReg[31:24];
        8'd3:       adqNext = addrReg[23:16];
        8'd4:       adqNext = addrReg[15:8];
        8'd5:       adqNext = addrReg[7:0];
        default:    adqNext = 8'h00;
      endcase
    end
  end

  // Re-arm only after iEn has been seen low; a held level never retriggers.
  always_ff @(posedge iClk or negedge iRst_N) begin
    if (!iRst_N)               armed <= 1'b1;
    else if (state == S_DONE)  armed <= 1'b0;
    else if (!bus.iEn)         armed <= 1'b1;
  end

  // Datapath and registered pad values
  always_ff @(posedge iClk or negedge iRst_N) begin
    if (!iRst_N) begin
      addrReg  <= '0;
      byteCnt  <= '0;
      dlyCnt   <= '0;
      edgeIdx  <= '0;
      rejReg   <= 1'b0;
      clkReg   <= 1'b0;
      ceReg    <= 1'b1;
      adqReg   <= 8'h00;
      adqOeReg <= 1'b0;
      dqsOeReg <= 1'b0;
      busyReg  <= 1'b0;
      doneReg  <= 1'b0;
      errReg   <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      errReg  <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          addrReg <= bus.iAddr;
          byteCnt <= bus.iLen;
          edgeIdx <= '0;
          busyReg <= 1'b1;
          rejReg  <= !lenOk;
          if (lenOk) begin
            ceReg    <= 1'b0;
            adqOeReg <= 1'b1;
            dqsOeReg <= 1'b1;
            adqReg   <= CMD_WR;
            dlyCnt   <= SETUP_LD;
          end
        end
        S_CE_LOW: if (dlyCnt != 8'd0) dlyCnt <= dlyCnt - 8'd1;
        S_SETUP: begin
          adqReg <= adqNext;
          if (inData) byteCnt <= byteCnt - 8'd1;
        end
        S_TOGGLE: begin
          clkReg  <= ~clkReg;
          edgeIdx <= edgeIdx + 8'd1;
          if (lastEdge) dlyCnt <= HOLD_LD;
        end
        S_HOLD: begin
          if (dlyCnt != 8'd0) dlyCnt <= dlyCnt - 8'd1;
          else begin
            ceReg    <= 1'b1;
            adqOeReg <= 1'b0;
            dqsOeReg <= 1'b0;
            adqReg   <= 8'h00;
          end
        end
        S_DONE: begin
          doneReg <= 1'b1;
          errReg  <= rejReg;
          busyReg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.oData_Req  = dataReq;
  assign bus.oPSRAM_CLK = clkReg;
  assign bus.oPSRAM_CE  = ceReg;
  assign bus.oADQ       = adqReg;
  assign bus.oADQ_OE    = adqOeReg;
  assign bus.oDQS_DM    = 1'b0;   // no byte masking on writes
  assign bus.oDQS_DM_OE = dqsOeReg;
  assign bus.oBusy      = busyReg;
  assign bus.oDone      = doneReg;
  assign bus.oErr       = errReg;

endmodule

// File: tb/tb_zpsram_burst_wr.sv
module tb_zpsram_burst_wr;
  localparam int LAT  = 5;
  localparam int CES  = 3;
  localparam int CEH  = 6;
  localparam int MAXL = 24;

  logic iClk, iRst_N;
  zpsram_burst_wr_if bus();

  zpsram_burst_wr #(.LATENCY(LAT), .CE_SETUP(CES), .CE_HOLD(CEH), .MAX_LEN(MAXL)) dut (
    .iClk   (iClk),
    .iRst_N (iRst_N),
    .bus    (bus)
  );

  initial iClk = 1'b0;
  always #10 iClk = ~iClk;

  int nVec, nErr;
  logic [7:0] fifoQ[$];
  logic [7:0] expQ[$];
  logic [7:0] obsQ[$];
  bit   popPend;
  logic lastClk, lastCe, errAtDone;
  int   cycN, reqCnt, ceLow, ceRise, lastFall, doneCnt, doneCyc, busyCnt;
  logic [7:0] rejLen[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One iClk cycle: FWFT FIFO model plus pad/status monitor, sampled 1 ns
  // after the rising edge.
  task automatic cyc();
    @(posedge iClk); #1;
    if (popPend && fifoQ.size() > 0) void'(fifoQ.pop_front());
    bus.iData = (fifoQ.size() > 0) ? fifoQ[0] : 8'h00;
    popPend = bus.oData_Req;
    cycN++;
    if (bus.oData_Req) reqCnt++;
    if (bus.oPSRAM_CLK !== lastClk) begin
      obsQ.push_back(bus.oADQ);
      if (!bus.oPSRAM_CLK) lastFall = cycN;
      lastClk = bus.oPSRAM_CLK;
    end
    if (!bus.oPSRAM_CE) ceLow++;
    if (bus.oPSRAM_CE && !lastCe) ceRise = cycN;
    lastCe = bus.oPSRAM_CE;
    if (bus.oDone) begin
      doneCnt++;
      doneCyc   = cycN;
      errAtDone = bus.oErr;
    end
    if (bus.oBusy) busyCnt++;
  endtask

  // Load FIFO, push the expected bus sequence to the scoreboard, drive the
  // descriptor and clear the monitor.
  task automatic setup_burst(input logic [31:0] addr, input logic [7:0] len,
                             input logic [7:0] first, input logic [7:0] step,
                             input bit ok);
    logic [7:0] b;
    fifoQ.delete(); expQ.delete(); obsQ.delete();
    b = first;
    if (ok) for (int i = 0; i < int'(len); i++) begin
      fifoQ.push_back(b);
      b = b + step;
    end
    if (ok) begin
      expQ.push_back(8'hA0); expQ.push_back(8'hA0);
      expQ.push_back(addr[31:24]); expQ.push_back(addr[23:16]);
      expQ.push_back(addr[15:8]);  expQ.push_back(addr[7:0]);
      for (int i = 0; i < 2 * LAT; i++) expQ.push_back(8'h00);
      for (int i = 0; i < fifoQ.size(); i++) expQ.push_back(fifoQ[i]);
    end
    bus.iAddr = addr;
    bus.iLen  = len;
    bus.iData = (fifoQ.size() > 0) ? fifoQ[0] : 8'h00;
    popPend = 0;
    cycN = 0; reqCnt = 0; ceLow = 0; ceRise = -1; lastFall = -1;
    doneCnt = 0; doneCyc = -1; busyCnt = 0; errAtDone = 1'bx;
    lastClk = bus.oPSRAM_CLK;
    lastCe  = bus.oPSRAM_CE;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (doneCnt == 0 && n < budget) begin
      cyc();
      n++;
    end
  endtask

  task automatic end_burst();
    bus.iEn = 1'b0;
    cyc();
  endtask

  task automatic check_burst(input logic [7:0] len, input bit ok);
    int n;
    logic [7:0] e, o;
    chk("done_cnt", doneCnt, 1);
    if (ok) begin
      chk("done_lat", doneCyc, 1 + CES + 4 * (3 + LAT) + 2 * int'(len) + CEH + 1);
      chk("err_at_done", errAtDone, 1'b0);
      chk("req_cnt", reqCnt, len);
      chk("ce_low", ceLow, CES + 4 * (3 + LAT) + 2 * int'(len) + CEH);
      chk("ce_hold", ceRise - lastFall, CEH);
      n = expQ.size();
      for (int i = 0; i < n; i++) begin
        e = expQ.pop_front();
        o = (obsQ.size() > 0) ? obsQ.pop_front() : 8'hxx;
        chk($sformatf("adq[%0d]", i), o, e);
      end
      chk("adq_extra", obsQ.size(), 0);
    end else begin
      chk("rej_lat", doneCyc, 2);
      chk("rej_err", errAtDone, 1'b1);
      chk("rej_req", reqCnt, 0);
      chk("rej_edges", obsQ.size(), 0);
      chk("rej_ce", ceLow, 0);
    end
    chk("idle_clk", bus.oPSRAM_CLK, 1'b0);
    chk("idle_ce", bus.oPSRAM_CE, 1'b1);
    chk("idle_oe", bus.oADQ_OE, 1'b0);
    chk("idle_busy", bus.oBusy, 1'b0);
  endtask

  initial begin
    nVec = 0; nErr = 0;
    lastClk = 1'b0; lastCe = 1'b1; popPend = 0;
    rejLen[0] = 8'd0; rejLen[1] = 8'd3; rejLen[2] = 8'd26;
    iRst_N = 1'b0;
    bus.iEn = 1'b0; bus.iAddr = '0; bus.iLen = '0; bus.iData = '0;

    // Reset values
    #25;
    chk("rst_clk", bus.oPSRAM_CLK, 1'b0);
    chk("rst_ce", bus.oPSRAM_CE, 1'b1);
    chk("rst_adq", bus.oADQ, 8'h00);
    chk("rst_adq_oe", bus.oADQ_OE, 1'b0);
    chk("rst_dm", bus.oDQS_DM, 1'b0);
    chk("rst_dm_oe", bus.oDQS_DM_OE, 1'b0);
    chk("rst_req", bus.oData_Req, 1'b0);
    chk("rst_busy", bus.oBusy, 1'b0);
    chk("rst_done", bus.oDone, 1'b0);
    chk("rst_err", bus.oErr, 1'b0);
    iRst_N = 1'b1;
    cyc(); cyc();

    // Normal burst
    setup_burst(32'h0000_0010, 8'd4, 8'h11, 8'h11, 1);
    bus.iEn = 1'b1;
    wait_done(400);
    end_burst();
    check_burst(8'd4, 1);

    // Rejected lengths
    for (int k = 0; k < 3; k++) begin
      setup_burst(32'h0000_0100, rejLen[k], 8'h00, 8'h00, 0);
      bus.iEn = 1'b1;
      wait_done(50);
      end_burst();
      check_burst(rejLen[k], 0);
    end

    // Level handshake: held iEn must not retrigger
    setup_burst(32'h0000_0020, 8'd4, 8'h51, 8'h01, 1);
    bus.iEn = 1'b1;
    wait_done(400);
    check_burst(8'd4, 1);
    busyCnt = 0; ceLow = 0; reqCnt = 0;
    repeat (200) cyc();
    chk("hold_busy", busyCnt, 0);
    chk("hold_ce", ceLow, 0);
    chk("hold_req", reqCnt, 0);
    chk("hold_done", doneCnt, 1);
    bus.iEn = 1'b0;
    cyc();
    setup_burst(32'h0000_0030, 8'd2, 8'h61, 8'h01, 1);
    bus.iEn = 1'b1;
    cyc();
    chk("restart_busy", bus.oBusy, 1'b1);
    wait_done(400);
    end_burst();
    check_burst(8'd2, 1);

    // Reset during the second data edge
    setup_burst(32'h0000_0040, 8'd4, 8'hC1, 8'h01, 1);
    bus.iEn = 1'b1;
    begin
      int n;
      n = 0;
      while (reqCnt < 2 && n < 400) begin cyc(); n++; end
    end
    chk("rst_reach", reqCnt, 2);
    chk("rst_pre_clk", bus.oPSRAM_CLK, 1'b1);
    iRst_N = 1'b0;
    #1;
    chk("arst_clk", bus.oPSRAM_CLK, 1'b0);
    chk("arst_ce", bus.oPSRAM_CE, 1'b1);
    chk("arst_adq_oe", bus.oADQ_OE, 1'b0);
    chk("arst_dm_oe", bus.oDQS_DM_OE, 1'b0);
    chk("arst_req", bus.oData_Req, 1'b0);
    chk("arst_busy", bus.oBusy, 1'b0);
    bus.iEn = 1'b0;
    repeat (5) cyc();
    chk("arst_nodone", doneCnt, 0);
    iRst_N = 1'b1;
    cyc();
    setup_burst(32'h1234_5678, 8'd2, 8'hAB, 8'h22, 1);
    bus.iEn = 1'b1;
    wait_done(400);
    end_burst();
    check_burst(8'd2, 1);

    // Maximum-length burst, incrementing data
    setup_burst(32'h00AB_CDEF, 8'd24, 8'h00, 8'h01, 1);
    bus.iEn = 1'b1;
    wait_done(400);
    end_burst();
    chk("max_ce_under_2us", (ceLow < 96) ? 32'd1 : 32'd0, 32'd1);
    check_burst(8'd24, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
